// File: rtl/nand2tetris_pkg.sv
// Shared types and widths for the RAM8 datapath blocks.
package nand2tetris_pkg;

    localparam int WORD_W      = 16;
    localparam int RAM8_ADDR_W = 3;

    typedef enum logic [1:0] {
        R8_IDLE,
        R8_CLEAR,
        R8_DONE
    } ram8_state_t;

    function automatic logic [RAM8_ADDR_W-1:0] r8_last_idx();
        return {RAM8_ADDR_W{1'b1}};
    endfunction

endpackage

// File: rtl/ram8_word_bank_register16.sv
// One storage word: synchronous active-low reset, load enable, synchronous zero.
module register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Zeroing has priority so the clear sequencer can never be overridden by a write.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ram8_word_bank.sv
// Eight-word bank feeding the RAM8 selector, with a one-word-per-cycle clear sequencer.
// Define RAM8_FORWARD_EN to forward write data combinationally onto the addressed output.
//
// state    | meaning
// R8_IDLE  | accepting writes, waiting for clear
// R8_CLEAR | zeroing word[cnt] each cycle, writes dropped
// R8_DONE  | one cycle after last word cleared, writes accepted
module ram8_word_bank
    import nand2tetris_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              in,
    input  logic                          load,
    input  logic [$clog2(DEPTH)-1:0]      address,
    input  logic                          clear,
    output logic [WIDTH-1:0]              out_a,
    output logic [WIDTH-1:0]              out_b,
    output logic [WIDTH-1:0]              out_c,
    output logic [WIDTH-1:0]              out_d,
    output logic [WIDTH-1:0]              out_e,
    output logic [WIDTH-1:0]              out_f,
    output logic [WIDTH-1:0]              out_g,
    output logic [WIDTH-1:0]              out_h,
    output logic                          busy,
    output logic                          clear_done
);

    localparam int ADDR_W = $clog2(DEPTH);

    ram8_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              clear_done_q, clear_done_d;

    logic              wr_accept;
    logic [DEPTH-1:0]  word_load;
    logic [DEPTH-1:0]  word_clr;
    logic [WIDTH-1:0]  word_q   [DEPTH];
    logic [WIDTH-1:0]  word_out [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            R8_IDLE: begin
                if (clear) begin
                    state_d = R8_CLEAR;
                end
            end
            R8_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = R8_DONE;
                end
            end
            R8_DONE: begin
                state_d = R8_IDLE;
            end
            default: begin
                state_d = R8_IDLE;
            end
        endcase
        busy_d       = (state_d == R8_CLEAR);
        clear_done_d = (state_d == R8_DONE);
    end

    // A clear request in IDLE takes precedence over a simultaneous write.
    assign wr_accept = load && ((state_q == R8_DONE) || ((state_q == R8_IDLE) && !clear));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= R8_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_load[i] = wr_accept && (address == ADDR_W'(i));
        assign word_clr[i]  = (state_q == R8_CLEAR) && (cnt_q == ADDR_W'(i));

        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (word_load[i]),
            .clr   (word_clr[i]),
            .d     (in),
            .q     (word_q[i])
        );

`ifdef RAM8_FORWARD_EN
        assign word_out[i] = word_load[i] ? in : word_q[i];
`else
        assign word_out[i] = word_q[i];
`endif
    end

    assign out_a      = word_out[0];
    assign out_b      = word_out[1];
    assign out_c      = word_out[2];
    assign out_d      = word_out[3];
    assign out_e      = word_out[4];
    assign out_f      = word_out[5];
    assign out_g      = word_out[6];
    assign out_h      = word_out[7];
    assign busy       = busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram8_word_bank.sv
// Directed self-checking bench for ram8_word_bank (honours RAM8_FORWARD_EN if defined).
module tb_ram8_word_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic        busy, clear_done;
    logic [15:0] outs [8];

    int vectors    = 0;
    int miscompares = 0;

    ram8_word_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .load       (load),
        .address    (address),
        .clear      (clear),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_g      (out_g),
        .out_h      (out_h),
        .busy       (busy),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;
    assign outs[4] = out_e;
    assign outs[5] = out_f;
    assign outs[6] = out_g;
    assign outs[7] = out_h;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_words(input string tag, input logic [15:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s word%0d", tag, i), outs[i], exp[i]);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        load = 1'b1; address = a; in = d;
        tick();
        load = 1'b0;
    endtask

    logic [15:0] exp_w [8];
    logic [15:0] fwd_exp;

    initial begin
        rst_n = 1'b0; in = '0; load = 1'b0; address = '0; clear = 1'b0;

        // Reset after some writes
        tick();
        rst_n = 1'b1;
        write(3'd3, 16'h3333);
        write(3'd7, 16'h7777);
        rst_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) exp_w[i] = 16'h0000;
        check_words("reset", exp_w);
        check("reset busy", {15'b0, busy}, 16'd0);
        check("reset clear_done", {15'b0, clear_done}, 16'd0);
        rst_n = 1'b1;
        tick();

        // Forwarding / same-cycle visibility
        load = 1'b1; address = 3'd0; in = 16'h1234;
        #1;
`ifdef RAM8_FORWARD_EN
        fwd_exp = 16'h1234;
`else
        fwd_exp = 16'h0000;
`endif
        check("same-cycle out_a", out_a, fwd_exp);
        tick();
        load = 1'b0;
        check("post-edge out_a", out_a, 16'h1234);
        exp_w[0] = 16'h1234;

        // Single write and hold
        write(3'd5, 16'hBEEF);
        exp_w[5] = 16'hBEEF;
        check_words("write5", exp_w);

        // Write all
        for (int i = 0; i < 8; i++) begin
            write(3'(i), 16'h1000 + 16'(i));
            exp_w[i] = 16'h1000 + 16'(i);
        end
        check_words("writeall", exp_w);

        // Clear sequence with collisions inside CLEAR
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("clr busy k%0d", k), {15'b0, busy}, 16'd1);
            check($sformatf("clr done k%0d", k), {15'b0, clear_done}, 16'd0);
            if (k == 2) begin load = 1'b1; address = 3'd0; in = 16'h5555; end
            if (k == 3) clear = 1'b1;
            tick();
            load = 1'b0;
            clear = 1'b0;
            check($sformatf("clr word%0d zero", k), outs[k], 16'h0000);
            if (k < 7) check($sformatf("clr word%0d held", k + 1), outs[k + 1], 16'h1000 + 16'(k + 1));
        end
        check("clr word0 dropped write", out_a, 16'h0000);
        check("done busy", {15'b0, busy}, 16'd0);
        check("done pulse", {15'b0, clear_done}, 16'd1);
        // Write accepted in DONE
        load = 1'b1; address = 3'd4; in = 16'h4444;
        tick();
        load = 1'b0;
        check("done pulse end", {15'b0, clear_done}, 16'd0);
        check("no restart busy", {15'b0, busy}, 16'd0);
        check("write in DONE", out_e, 16'h4444);

        // clear + load collision in IDLE
        write(3'd2, 16'h2222);
        clear = 1'b1; load = 1'b1; address = 3'd2; in = 16'h00AA;
        tick();
        clear = 1'b0; load = 1'b0;
        check("collide busy", {15'b0, busy}, 16'd1);
        check("collide write dropped", out_c, 16'h2222);
        for (int k = 0; k < 9; k++) tick();
        check("collide out_c end", out_c, 16'h0000);
        check("collide idle", {15'b0, busy | clear_done}, 16'd0);

        // Reset during the 4th CLEAR cycle
        for (int i = 0; i < 8; i++) write(3'(i), 16'hA000 + 16'(i));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(); tick(); tick();
        check("midclr busy before", {15'b0, busy}, 16'd1);
        check("midclr word4 intact", out_e, 16'hA004);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_w[i] = 16'h0000;
        check_words("midclr reset", exp_w);
        check("midclr busy", {15'b0, busy}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("midclr no done c%0d", k), {15'b0, clear_done | busy}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
